half_adder_arbiter: RTL and testbench

- Shares one half_adder instance between NUM_REQ requesters using a round-robin arbiter.
- A controller FSM accepts one operand pair, drives the shared adder, registers the result and presents it on a single response channel with a valid/ready handshake.
- Sits between several stimulus/agent sources and the half-adder datapath in the ip-cores-sv test environment.
- Output data packing matches the existing half-adder bus format.

---
 rtl/half_adder_arbiter.sv | 131 +++++++++++++
 tb/tb_half_adder_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/half_adder_arbiter.sv
// Round-robin front end that time-shares a single half adder between NUM_REQ
// requesters and returns each result on one valid/ready response channel.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module half_adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [3:0]           resp_data,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg;
  logic [ID_W-1:0]  ptr_reg;
  logic [ID_W-1:0]  id_reg;
  logic             a_reg;
  logic             b_reg;
  logic             resp_valid_reg;
  logic [ID_W-1:0]  resp_id_reg;
  logic [3:0]       resp_data_reg;
  logic [CNT_W-1:0] op_count_reg;

  logic             ha_s;
  logic             ha_c;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand_idx;
  logic [1:0]       req_pair [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_pair[gi] = req_data[2*gi +: 2];
    end
  endgenerate

  // Search starts just after the last grant, so the last winner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_idx = ID_W'((int'(ptr_reg) + off) % NUM_REQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_reg == IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  half_adder u_half_adder (
    .a (a_reg),
    .b (b_reg),
    .s (ha_s),
    .c (ha_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      ptr_reg        <= ID_W'(NUM_REQ - 1);
      id_reg         <= '0;
      a_reg          <= 1'b0;
      b_reg          <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_id_reg    <= '0;
      resp_data_reg  <= '0;
      op_count_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            a_reg     <= req_pair[grant_idx][0];
            b_reg     <= req_pair[grant_idx][1];
            ptr_reg   <= grant_idx;
            id_reg    <= grant_idx;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          resp_data_reg  <= {ha_s, ha_c, b_reg, a_reg};
          resp_id_reg    <= id_reg;
          resp_valid_reg <= 1'b1;
          state_reg      <= RESP;
        end
        RESP: begin
          if (resp_valid_reg && resp_ready) begin
            resp_valid_reg <= 1'b0;
            op_count_reg   <= op_count_reg + 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_id    = resp_id_reg;
  assign resp_data  = resp_data_reg;
  assign op_count   = op_count_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_half_adder_arbiter.sv
// Directed bench for half_adder_arbiter: a 16-bit counter instance and a 2-bit
// counter instance run on identical stimulus.

module tb_half_adder_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_valid;
  logic [7:0] req_data;
  logic       resp_ready;

  logic [3:0]  req_ready,  req_ready2;
  logic        resp_valid, resp_valid2;
  logic [1:0]  resp_id,    resp_id2;
  logic [3:0]  resp_data,  resp_data2;
  logic        busy,       busy2;
  logic [15:0] op_count;
  logic [1:0]  op_count2;

  int checks = 0;
  int passes = 0;
  int exp_cnt = 0;

  half_adder_arbiter #(.NUM_REQ(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .busy(busy), .op_count(op_count)
  );

  half_adder_arbiter #(.NUM_REQ(4), .CNT_W(2)) dut_wrap (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready2), .resp_valid(resp_valid2), .resp_ready(resp_ready),
    .resp_id(resp_id2), .resp_data(resp_data2), .busy(busy2), .op_count(op_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (resp_valid !== 1'b0) $display("FAIL reset.resp_valid got %b want 0", resp_valid); else passes++;
    checks++; if (req_ready !== 4'b0) $display("FAIL reset.req_ready got %b want 0000", req_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset.busy got %b want 0", busy); else passes++;
    checks++; if (op_count !== 16'd0) $display("FAIL reset.op_count got %0d want 0", op_count); else passes++;
    checks++; if (resp_data !== 4'h0 || resp_id !== 2'd0) $display("FAIL reset.resp got %h/%0d want 0/0", resp_data, resp_id); else passes++;
    step();
    rst = 1'b0;
    // Park an operation in RESP, then reset asynchronously mid-cycle.
    req_valid = 4'b0010;
    req_data  = 8'b0000_0100;
    step();
    req_valid = 4'b0000;
    step();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 4'h9) $display("FAIL reset.pre_resp got %b/%h want 1/9", resp_valid, resp_data); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0) $display("FAIL reset.mid_resp_valid got %b want 0", resp_valid); else passes++;
    checks++; if (busy !== 1'b0 || req_ready !== 4'b0) $display("FAIL reset.mid_busy_ready got %b/%b want 0/0000", busy, req_ready); else passes++;
    checks++; if (resp_data !== 4'h0 || op_count !== 16'd0) $display("FAIL reset.mid_data_cnt got %h/%0d want 0/0", resp_data, op_count); else passes++;
    step();
    rst = 1'b0;
    resp_ready = 1'b1;
    step();
    step();
    checks++; if (resp_valid !== 1'b0 || op_count !== 16'd0) $display("FAIL reset.discard got %b/%0d want 0/0", resp_valid, op_count); else passes++;
  endtask

  task automatic test_single();
    resp_ready = 1'b1;
    req_valid  = 4'b0100;
    req_data   = 8'b0011_0000;
    #1;
    checks++; if (req_ready !== 4'b0100) $display("FAIL single.req_ready got %b want 0100", req_ready); else passes++;
    step();
    req_valid = 4'b0000;
    checks++; if (busy !== 1'b1 || req_ready !== 4'b0 || resp_valid !== 1'b0) $display("FAIL single.exec got busy=%b ready=%b valid=%b want 1/0000/0", busy, req_ready, resp_valid); else passes++;
    step();
    checks++; if (resp_valid !== 1'b1) $display("FAIL single.resp_valid got %b want 1", resp_valid); else passes++;
    checks++; if (resp_data !== 4'b0111) $display("FAIL single.resp_data got %h want 7", resp_data); else passes++;
    checks++; if (resp_id !== 2'd2) $display("FAIL single.resp_id got %0d want 2", resp_id); else passes++;
    $display("txn single id=%0d data=%h", resp_id, resp_data);
    step();
    exp_cnt++;
    checks++; if (op_count !== 16'd1 || resp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single.done got cnt=%0d valid=%b busy=%b want 1/0/0", op_count, resp_valid, busy); else passes++;
  endtask

  task automatic test_truth_table();
    logic [1:0] ab  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};  // {b,a}
    logic [3:0] exp [4] = '{4'h0, 4'h9, 4'hA, 4'h7};
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 4'b0001;
      req_data  = {6'b0, ab[i]};
      #1;
      checks++; if (req_ready !== 4'b0001) $display("FAIL truth%0d.req_ready got %b want 0001", i, req_ready); else passes++;
      step();
      req_valid = 4'b0000;
      step();
      checks++; if (resp_valid !== 1'b1 || resp_data !== exp[i] || resp_id !== 2'd0) $display("FAIL truth%0d.resp got v=%b d=%h id=%0d want 1/%h/0", i, resp_valid, resp_data, resp_id, exp[i]); else passes++;
      $display("txn truth id=%0d data=%h", resp_id, resp_data);
      step();
      exp_cnt++;
      checks++; if (op_count !== 16'(exp_cnt)) $display("FAIL truth%0d.op_count got %0d want %0d", i, op_count, exp_cnt); else passes++;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] by_id  [4] = '{4'h0, 4'h9, 4'hA, 4'h7};
    do_reset();
    resp_ready = 1'b1;
    req_data   = 8'b11_10_01_00;
    req_valid  = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (req_ready !== (4'b0001 << exp_id[i])) $display("FAIL rr%0d.req_ready got %b want id %0d", i, req_ready, exp_id[i]); else passes++;
      step();
      checks++; if (req_ready !== 4'b0) $display("FAIL rr%0d.exec_ready got %b want 0000", i, req_ready); else passes++;
      step();
      checks++; if (resp_valid !== 1'b1 || resp_id !== exp_id[i] || resp_data !== by_id[exp_id[i]]) $display("FAIL rr%0d.resp got v=%b id=%0d d=%h want 1/%0d/%h", i, resp_valid, resp_id, resp_data, exp_id[i], by_id[exp_id[i]]); else passes++;
      $display("txn rr id=%0d data=%h", resp_id, resp_data);
      step();
      exp_cnt++;
    end
    req_valid = 4'b0000;
    checks++; if (op_count !== 16'(exp_cnt)) $display("FAIL rr.op_count got %0d want %0d", op_count, exp_cnt); else passes++;
  endtask

  task automatic test_backpressure();
    // Pointer is 0 here; requester 3 is alone, so it wins.
    resp_ready = 1'b0;
    req_valid  = 4'b1000;
    req_data   = 8'b01_00_00_00;
    #1;
    checks++; if (req_ready !== 4'b1000) $display("FAIL bp.first_ready got %b want 1000", req_ready); else passes++;
    step();
    req_valid = 4'b0010;
    req_data  = 8'b00_00_11_00;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid !== 1'b1 || resp_data !== 4'h9 || resp_id !== 2'd3) $display("FAIL bp%0d.hold got v=%b d=%h id=%0d want 1/9/3", i, resp_valid, resp_data, resp_id); else passes++;
      checks++; if (req_ready !== 4'b0 || op_count !== 16'(exp_cnt)) $display("FAIL bp%0d.stall got ready=%b cnt=%0d want 0000/%0d", i, req_ready, op_count, exp_cnt); else passes++;
      step();
    end
    $display("txn bp id=%0d data=%h", resp_id, resp_data);
    resp_ready = 1'b1;
    step();
    exp_cnt++;
    checks++; if (req_ready !== 4'b0010 || op_count !== 16'(exp_cnt)) $display("FAIL bp.release got ready=%b cnt=%0d want 0010/%0d", req_ready, op_count, exp_cnt); else passes++;
    step();
    req_valid = 4'b0000;
    step();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 4'h7 || resp_id !== 2'd1) $display("FAIL bp.second got v=%b d=%h id=%0d want 1/7/1", resp_valid, resp_data, resp_id); else passes++;
    $display("txn bp id=%0d data=%h", resp_id, resp_data);
    step();
    exp_cnt++;
    // resp_ready with nothing pending must not count.
    step();
    step();
    checks++; if (op_count !== 16'(exp_cnt) || resp_valid !== 1'b0) $display("FAIL bp.idle_ready got cnt=%0d v=%b want %0d/0", op_count, resp_valid, exp_cnt); else passes++;
  endtask

  task automatic test_counter_wrap();
    logic [1:0] exp_wrap [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    resp_ready = 1'b1;
    req_data   = 8'b0000_0001;
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b0001;
      step();
      req_valid = 4'b0000;
      step();
      $display("txn wrap id=%0d data=%h", resp_id2, resp_data2);
      step();
      exp_cnt++;
      checks++; if (op_count2 !== exp_wrap[i]) $display("FAIL wrap%0d.op_count2 got %0d want %0d", i, op_count2, exp_wrap[i]); else passes++;
      checks++; if (op_count !== 16'(exp_cnt)) $display("FAIL wrap%0d.op_count got %0d want %0d", i, op_count, exp_cnt); else passes++;
    end
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 4'b0000;
    req_data   = 8'h00;
    resp_ready = 1'b0;
    #2 rst = 1'b1;
    test_reset();
    test_single();
    test_truth_table();
    test_round_robin();
    test_backpressure();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
